instr_fetcher: RTL

INSTR_FETCHER -- requirements
Module: instr_fetcher

---
 rtl/instr_fetcher_pkg.sv | 32 +++
 rtl/instr_fetcher_inst_queue.sv | 87 ++++++++
 rtl/instr_fetcher.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/instr_fetcher_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetcher_pkg
//   Shared configuration for the instruction fetcher. It holds:
//     - the default instruction queue depth
//     - the RISC-V JAL opcode used by the optional static branch predictor
//     - the fetch FSM state encodings (also visible on dbg_state_o)
//     - the queue entry layout and the J-type immediate decoder
//   Optional feature macro: JAL_PREDICT_EN (used by instr_fetcher).
// -----------------------------------------------------------------------------
package instr_fetcher_pkg;

    localparam int IQ_DEPTH_DEFAULT = 4;

    localparam logic [6:0] OPC_JAL = 7'b1101111;

    // Fetch FSM encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
    } iq_entry_t;

    // Sign-extended J-type immediate: {i[31], i[19:12], i[20], i[30:21], 0}
    function automatic logic [31:0] jal_imm(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/instr_fetcher_inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
//   Circular instruction buffer with first-word fall-through read: the head
//   entry is driven combinationally, so a push is visible on head_o the cycle
//   after it is written.
//   Ports:
//     clk_in, rst_n_in   clock, synchronous active-low reset
//     en_i               global enable; low freezes pointers, count and storage
//     clr_i              synchronous clear (pointers and count to zero)
//     push_i/push_entry_i  write an entry at the tail
//     pop_i              retire the head entry (ignored when empty)
//     head_o             head entry (undefined contents when count_o == 0)
//     count_o            number of valid entries
//   DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
import instr_fetcher_pkg::*;

module inst_queue #(
    parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     en_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  iq_entry_t                push_entry_i,
    input  logic                     pop_i,
    output iq_entry_t                head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    iq_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;
    logic               wr_en;

    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        // A full queue can still accept a push when the head leaves the same cycle.
        do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_en   = en_i && rst_n_in && !clr_i && do_push;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clr_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + 1'b1;
            if (do_pop)  head_d = head_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (en_i) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk_in) begin
        if (wr_en) mem_q[tail_q] <= push_entry_i;
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetcher.sv
// -----------------------------------------------------------------------------
// instr_fetcher
//   Sequential instruction fetch unit. Issues one word-aligned request at a
//   time to the icache, buffers returned instructions in an inst_queue and
//   presents the head to the decoder.
//   Optional feature macro: JAL_PREDICT_EN -- predicts JAL as taken and
//   redirects the fetch PC to the jump target.
//   Ports:
//     clk_in, rst_n_in          clock, synchronous active-low reset
//     rdy_in                    global enable; low freezes all state
//     ic_req_valid, ic_req_addr icache request (held until ic_resp_valid)
//     ic_resp_valid, ic_resp_data  one-cycle icache data return
//     inst_valid, inst_out, inst_pc, inst_pred_taken  queue head to decoder
//     dispatch_ready            decoder accepts the head this cycle
//     flush_in, flush_pc_in     redirect: clear queue, restart fetch at target
//     dbg_state_o               current fetch FSM state (ST_* encodings)
//
//   Handshakes: the decoder side is valid/ready -- an entry transfers on every
//   rising edge where inst_valid && dispatch_ready (and rdy_in, no flush);
//   inst_valid never drops without a transfer except on flush or reset. The
//   icache side is request/response -- ic_req_valid stays high with a stable
//   ic_req_addr until the single-cycle ic_resp_valid pulse returns the data.
// -----------------------------------------------------------------------------
import instr_fetcher_pkg::*;

module instr_fetcher #(
    parameter int          IQ_DEPTH = IQ_DEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    output logic        ic_req_valid,
    output logic [31:0] ic_req_addr,
    input  logic        ic_resp_valid,
    input  logic [31:0] ic_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        inst_pred_taken,
    input  logic        dispatch_ready,
    input  logic        flush_in,
    input  logic [31:0] flush_pc_in,
    output logic [1:0]  dbg_state_o
);

    localparam int CNT_W = $clog2(IQ_DEPTH) + 1;

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_addr_q, req_addr_d;

    logic             iq_push;
    logic             iq_pop;
    iq_entry_t        iq_push_entry;
    iq_entry_t        iq_head;
    logic [CNT_W-1:0] iq_count;

    logic             pred_taken;
    logic [31:0]      next_pc;

    // Next sequential/predicted PC for the instruction being returned now.
`ifdef JAL_PREDICT_EN
    always_comb begin
        pred_taken = (ic_resp_data[6:0] == OPC_JAL);
        next_pc    = pred_taken ? (pc_q + jal_imm(ic_resp_data)) : (pc_q + 32'd4);
    end
`else
    always_comb begin
        pred_taken = 1'b0;
        next_pc    = pc_q + 32'd4;
    end
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        iq_push    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (flush_in) begin
                    pc_d = flush_pc_in;
                end else if (iq_count != CNT_W'(IQ_DEPTH)) begin
                    // Only one request is ever outstanding, so one free slot
                    // is enough to guarantee the response can be pushed.
                    state_d    = ST_BUSY;
                    req_addr_d = pc_q;
                end
            end
            ST_BUSY: begin
                if (flush_in) begin
                    pc_d    = flush_pc_in;
                    state_d = ic_resp_valid ? ST_IDLE : ST_DISCARD;
                end else if (ic_resp_valid) begin
                    iq_push = 1'b1;
                    pc_d    = next_pc;
                    state_d = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                // Wait out the stale request; its data is dropped.
                if (flush_in)      pc_d    = flush_pc_in;
                if (ic_resp_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else if (rdy_in) begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    always_comb begin
        iq_push_entry.instr = ic_resp_data;
        iq_push_entry.pc    = pc_q;
        iq_push_entry.pred  = pred_taken;
    end

    assign iq_pop = inst_valid && dispatch_ready && !flush_in;

    inst_queue #(
        .DEPTH (IQ_DEPTH)
    ) u_inst_queue (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .en_i         (rdy_in),
        .clr_i        (flush_in),
        .push_i       (iq_push),
        .push_entry_i (iq_push_entry),
        .pop_i        (iq_pop),
        .head_o       (iq_head),
        .count_o      (iq_count)
    );

    assign ic_req_valid = (state_q == ST_BUSY) || (state_q == ST_DISCARD);
    assign ic_req_addr  = req_addr_q;
    assign inst_valid   = (iq_count != '0);
    assign inst_out     = iq_head.instr;
    assign inst_pc      = iq_head.pc;
    assign dbg_state_o  = state_q;

`ifdef JAL_PREDICT_EN
    assign inst_pred_taken = inst_valid && iq_head.pred;
`else
    logic unused_pred;
    assign unused_pred     = iq_head.pred;
    assign inst_pred_taken = 1'b0;
`endif

endmodule
